// File: rtl/clmul_pkg.sv
// Shared types and sizing helpers for the sequential carry-less multiplier.
package clmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int steps(input int w, input int d);
        return w / d;
    endfunction

    // Step counter must hold 0..steps-1 and never collapse to zero bits
    function automatic int cnt_width(input int w, input int d);
        return ($clog2(w / d) < 1) ? 1 : $clog2(w / d);
    endfunction

endpackage

// File: rtl/clmul_if.sv
// Request/result bundle of clmul_seq: operands and start in, busy/done/product out.
interface clmul_if #(
    parameter int W = 32
);
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   p;

    modport master (output start, output a, output b, input busy, input done, input p);
    modport slave  (input start, input a, input b, output busy, output done, output p);
endinterface

// File: rtl/clmul_digit.sv
// One multiplier digit: XOR-accumulates b_j * (a_sh << j) for the D bits of the current step.
module clmul_digit
    import clmul_pkg::*;
#(
    parameter int W = 32,
    parameter int D = 1
) (
    input  logic [2*W-1:0] a_sh,
    input  logic [D-1:0]   b_bits,
    input  logic [2*W-1:0] acc_in,
    output logic [2*W-1:0] acc_out
);

    // Partial products of all D bits folded into the accumulator in one pass
    always_comb begin
        acc_out = acc_in;
        for (int j = 0; j < D; j++) begin
            if (b_bits[j]) begin
                acc_out = acc_out ^ (a_sh << j);
            end else begin
                acc_out = acc_out;
            end
        end
    end

endmodule

// File: rtl/clmul_seq.sv
// Sequential GF(2)[x] multiplier, D multiplier bits per cycle, sticky done.
// Optional: CLMUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
module clmul_seq
    import clmul_pkg::*;
#(
    parameter int W = 32,
    parameter int D = 1
) (
    input  logic   clk,
    input  logic   rst,
    clmul_if.slave bus
);

    localparam int             NSTEPS = steps(W, D);
    localparam int             CW     = cnt_width(W, D);
    localparam logic [CW-1:0]  LAST   = CW'(NSTEPS - 1);
    localparam logic [1:0]     S_IDLE = IDLE;
    localparam logic [1:0]     S_BUSY = BUSY;
    localparam logic [1:0]     S_DONE = DONE;

    logic [1:0]     state_r;
    logic [2*W-1:0] a_sh_r;
    logic [W-1:0]   b_sh_r;
    logic [2*W-1:0] acc_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r;
    logic           done_r;
    logic [2*W-1:0] p_r;

    logic [2*W-1:0] acc_nxt_s;
    logic [W-1:0]   b_sh_nxt_s;
    logic           finish_s;

    clmul_digit #(.W(W), .D(D)) u_digit (
        .a_sh    (a_sh_r),
        .b_bits  (b_sh_r[D-1:0]),
        .acc_in  (acc_r),
        .acc_out (acc_nxt_s)
    );

    // Decide whether the current BUSY edge is the final step
    always_comb begin
        b_sh_nxt_s = b_sh_r >> D;
`ifdef CLMUL_EARLY_EXIT_EN
        finish_s   = (cnt_r == LAST) || (b_sh_nxt_s == {W{1'b0}});
`else
        finish_s   = (cnt_r == LAST);
`endif
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            a_sh_r  <= {(2*W){1'b0}};
            b_sh_r  <= {W{1'b0}};
            acc_r   <= {(2*W){1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            p_r     <= {(2*W){1'b0}};
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        a_sh_r  <= {{W{1'b0}}, bus.a};
                        b_sh_r  <= bus.b;
                        acc_r   <= {(2*W){1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    acc_r  <= acc_nxt_s;
                    a_sh_r <= a_sh_r << D;
                    b_sh_r <= b_sh_nxt_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (finish_s) begin
                        p_r     <= acc_nxt_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.p    = p_r;

endmodule

// File: tb/tb_clmul_seq.sv
// Scoreboard bench for clmul_seq: a D=1 and a D=4 instance, directed vectors, per-run latency check.
module tb_clmul_seq;

    typedef struct {
        logic [63:0] p;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    int   cnt_a = 0;
    int   cnt_b = 0;
    bit   prev_a = 1'b0;
    bit   prev_b = 1'b0;

    clmul_if #(.W(32)) ifa ();
    clmul_if #(.W(32)) ifb ();

    clmul_seq #(.W(32), .D(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    clmul_seq #(.W(32), .D(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, ex);
        end
    endfunction

    function automatic int exp_lat(input logic [31:0] bv, input int d);
        int m;
        m = -1;
        for (int i = 0; i < 32; i++) if (bv[i]) m = i;
`ifdef CLMUL_EARLY_EXIT_EN
        if (m < 0) return 1;
        return (m + d) / d;
`else
        return 32 / d;
`endif
    endfunction

    task automatic push(input bit sel, input logic [63:0] ep, input logic [31:0] bv);
        exp_t e;
        e.p   = ep;
        e.lat = exp_lat(bv, sel ? 4 : 1);
        if (sel) qb.push_back(e);
        else     qa.push_back(e);
    endtask

    task automatic wait_done(input bit sel, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = sel ? ifb.done : ifa.done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done got 0 expected 1 within 200 cycles", nm);
        end
    endtask

    task automatic run(input bit sel, input logic [31:0] ta, input logic [31:0] tbv,
                       input logic [63:0] ep, input string nm);
        push(sel, ep, tbv);
        @(negedge clk);
        if (sel) begin ifb.start = 1'b1; ifb.a = ta; ifb.b = tbv; end
        else     begin ifa.start = 1'b1; ifa.a = ta; ifa.b = tbv; end
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        wait_done(sel, nm);
    endtask

    // Monitor for the D=1 instance: compare product, latency and busy on each done rise
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt_a = 0; prev_a = 1'b0;
            end else begin
                if (ifa.busy) cnt_a++;
                if (ifa.done && !prev_a) begin
                    if (qa.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL a_unexpected_done: got done=1 expected no result pending");
                    end else begin
                        e = qa.pop_front();
                        chk("a_p", ifa.p, e.p);
                        chk("a_latency", 64'(cnt_a), 64'(e.lat));
                        chk("a_busy_at_done", 64'(ifa.busy), 64'd0);
                    end
                    cnt_a = 0;
                end
                prev_a = ifa.done;
            end
        end
    end

    // Monitor for the D=4 instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt_b = 0; prev_b = 1'b0;
            end else begin
                if (ifb.busy) cnt_b++;
                if (ifb.done && !prev_b) begin
                    if (qb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL b_unexpected_done: got done=1 expected no result pending");
                    end else begin
                        e = qb.pop_front();
                        chk("b_p", ifb.p, e.p);
                        chk("b_latency", 64'(cnt_b), 64'(e.lat));
                        chk("b_busy_at_done", 64'(ifb.busy), 64'd0);
                    end
                    cnt_b = 0;
                end
                prev_b = ifb.done;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        ifa.start = 1'b0; ifa.a = 32'h0; ifa.b = 32'h0;
        ifb.start = 1'b0; ifb.a = 32'h0; ifb.b = 32'h0;
        #12;
        chk("rst_a_busy", 64'(ifa.busy), 64'd0);
        chk("rst_a_done", 64'(ifa.done), 64'd0);
        chk("rst_a_p", ifa.p, 64'd0);
        chk("rst_b_p", ifb.p, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run(1'b0, 32'h3,        32'h3,        64'h5,                 "a_3x3");
        run(1'b0, 32'h14,       32'h7,        64'h6C,                "a_14x7");
        run(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h5555555555555555,  "a_ones");
        run(1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000,  "a_msb");
        repeat (5) @(negedge clk);
        chk("a_p_stable", ifa.p, 64'h4000000000000000);
        chk("a_done_stable", 64'(ifa.done), 64'd1);
        run(1'b0, 32'h100,      32'h80000001, 64'h0000008000000100,  "a_sparse");
        run(1'b0, 32'h12345678, 32'h0,        64'h0,                 "a_bzero");

        // Back-to-back: start held high, second operands accepted on the first DONE edge
        push(1'b0, 64'h11, 32'h5);
        @(negedge clk);
        ifa.start = 1'b1; ifa.a = 32'h5; ifa.b = 32'h5;
        wait_done(1'b0, "a_b2b_first");
        push(1'b0, 64'h00000000DEADBEEF, 32'hDEADBEEF);
        ifa.a = 32'h1; ifa.b = 32'hDEADBEEF;
        @(negedge clk);
        ifa.start = 1'b0;
        chk("a_b2b_done_cleared", 64'(ifa.done), 64'd0);
        chk("a_b2b_p_held", ifa.p, 64'h11);
        wait_done(1'b0, "a_b2b_second");

        // D=4 instance, including a start pulse with other operands mid-run
        run(1'b1, 32'h14, 32'h7, 64'h6C, "b_14x7");
        push(1'b1, 64'h0000000100000001, 32'hFFFFFFFF);
        @(negedge clk);
        ifb.start = 1'b1; ifb.a = 32'h3; ifb.b = 32'hFFFFFFFF;
        @(negedge clk);
        ifb.start = 1'b0;
        repeat (3) @(negedge clk);
        ifb.start = 1'b1; ifb.a = 32'h1234; ifb.b = 32'h55;
        @(negedge clk);
        ifb.start = 1'b0;
        wait_done(1'b1, "b_midbusy");

        // Asynchronous reset in the middle of a D=1 run
        @(negedge clk);
        ifa.start = 1'b1; ifa.a = 32'h3; ifa.b = 32'hFFFFFFFF;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("a_busy_before_rst", 64'(ifa.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("a_async_rst_busy", 64'(ifa.busy), 64'd0);
        chk("a_async_rst_done", 64'(ifa.done), 64'd0);
        chk("a_async_rst_p", ifa.p, 64'd0);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("a_start_in_rst_ignored", 64'(ifa.busy), 64'd0);
        run(1'b0, 32'h14, 32'h7, 64'h6C, "a_after_rst");

        repeat (3) @(negedge clk);
        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
